// File: rtl/seq_pattern_rx.sv
// Serial 4-bit pattern detector with fill tracking and wrapping match count.
// Define SEQ_RX_OVERLAP_EN for overlapping detection; default is non-overlapping.
module seq_pattern_rx #(
  parameter logic [3:0] PATTERN = 4'b1011,
  parameter int         CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_wrap,
  output logic [3:0]       window,
  output logic [2:0]       fill
);

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    FILL1 = 3'd1,
    FILL2 = 3'd2,
    FILL3 = 3'd3,
    ARMED = 3'd4
  } fill_e;

  fill_e            fill_q, fill_d;
  logic [3:0]       win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_q, match_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    fill_d  = fill_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    match_d = 1'b0;
    wrap_d  = 1'b0;
    if (din_valid) begin
      win_d = {win_q[2:0], din};
      unique case (fill_q)
        EMPTY:   fill_d = FILL1;
        FILL1:   fill_d = FILL2;
        FILL2:   fill_d = FILL3;
        default: fill_d = ARMED;
      endcase
      if (fill_d == ARMED && win_d == PATTERN) begin
        match_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        wrap_d  = &cnt_q;
`ifndef SEQ_RX_OVERLAP_EN
        // window keeps shifting, but four fresh bits are needed
        fill_d  = EMPTY;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_q  <= EMPTY;
      win_q   <= 4'b0000;
      cnt_q   <= '0;
      match_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      wrap_q  <= wrap_d;
    end
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign count_wrap  = wrap_q;
  assign window      = win_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_seq_pattern_rx.sv
// Bench for seq_pattern_rx: bit-history model checked every cycle,
// plus directed literal checks.
module tb_seq_pattern_rx;

  localparam logic [3:0] PAT   = 4'b1011;
  localparam int         CNT_W = 4;

`ifdef SEQ_RX_OVERLAP_EN
  localparam int L_CNT  = 2;
  localparam int L_FILL = 4;
`else
  localparam int L_CNT  = 1;
  localparam int L_FILL = 3;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             count_wrap;
  logic [3:0]       window;
  logic [2:0]       fill;

  seq_pattern_rx #(.PATTERN(PAT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .match       (match),
    .match_count (match_count),
    .count_wrap  (count_wrap),
    .window      (window),
    .fill        (fill)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit run = 1'b0;

  bit   acc[$];
  int   since;
  int   nmatch;
  logic       exp_match, exp_wrap;
  logic [3:0] exp_win, exp_cnt;
  logic [2:0] exp_fill;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_clear();
    acc.delete();
    since     = 0;
    nmatch    = 0;
    exp_match = 1'b0;
    exp_wrap  = 1'b0;
    exp_win   = 4'b0000;
    exp_cnt   = 4'd0;
    exp_fill  = 3'd0;
  endtask

  // Expected outputs after the next edge, from the history of accepted bits
  task automatic model_bit(input bit v, input bit d);
    logic [3:0] w;
    exp_match = 1'b0;
    exp_wrap  = 1'b0;
    if (v) begin
      acc.push_back(d);
      since++;
      w = 4'b0000;
      for (int i = 0; i < 4; i++)
        if (acc.size() > i) w[i] = acc[acc.size() - 1 - i];
      exp_win = w;
      if (since >= 4 && w == PAT) begin
        nmatch++;
        exp_match = 1'b1;
        exp_wrap  = (nmatch % 16) == 0;
`ifndef SEQ_RX_OVERLAP_EN
        since = 0;
`endif
      end
      exp_fill = 3'(since > 4 ? 4 : since);
      exp_cnt  = 4'(nmatch % 16);
    end
  endtask

  // Called at negedge+1; returns at the following negedge+1
  task automatic step(input bit v, input bit d);
    din_valid = v;
    din       = d;
    model_bit(v, d);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    din_valid = 1'b0;
    din       = 1'b0;
    model_bit(1'b0, 1'b0);
    #6;
    reset = 1'b0;
    model_clear();
    #1;
    chk("arst_match", match, 0);
    chk("arst_count", match_count, 0);
    chk("arst_wrap", count_wrap, 0);
    chk("arst_window", window, 0);
    chk("arst_fill", fill, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("cyc_match", match, exp_match);
      chk("cyc_count", match_count, exp_cnt);
      chk("cyc_wrap", count_wrap, exp_wrap);
      chk("cyc_window", window, exp_win);
      chk("cyc_fill", fill, exp_fill);
    end
  end

  initial begin
    bit s7[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit s4[4] = '{1, 0, 1, 1};

    model_clear();
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'($urandom);
      din       = 1'($urandom);
      @(negedge clk);
      #1;
    end
    chk("hold_rst_count", match_count, 0);
    chk("hold_rst_window", window, 0);
    din_valid = 1'b0;
    reset = 1'b1;

    // Stream 1011011
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s7[i]);
      if (i == 3) chk("s7_match_b4", match, 1);
      if (i == 4) chk("s7_match_b5", match, 0);
    end
    chk("s7_model_cnt", exp_cnt, L_CNT);
    chk("s7_count", match_count, L_CNT);
    chk("s7_fill", fill, L_FILL);
    chk("s7_window", window, 4'b1011);
    chk("s7_match_b7", match, L_CNT == 2 ? 1 : 0);

    // Valid gaps with din toggling
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, s4[i]);
      if (i == 3) begin
        chk("gap_match", match, 1);
        chk("gap_model_match", exp_match, 1);
        step(1'b0, 1'b0);
        chk("gap_match_low", match, 0);
      end else begin
        for (int g = 0; g < 3; g++) step(1'b0, 1'(g));
        chk("gap_fill", fill, i + 1);
      end
    end
    chk("gap_count", match_count, 1);

    // 16 detections wrap the 4-bit count
    pulse_reset();
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 4; i++) step(1'b1, s4[i]);
      if (r == 14) begin
        chk("wrap_cnt15", match_count, 15);
        chk("wrap_early", count_wrap, 0);
      end
    end
    chk("wrap_count0", match_count, 0);
    chk("wrap_pulse", count_wrap, 1);
    chk("wrap_match", match, 1);
    step(1'b0, 1'b1);
    chk("wrap_pulse_end", count_wrap, 0);

    // Reset mid-pattern
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b1, s4[i]);
    chk("mid_window", window, 4'b0101);
    chk("mid_fill", fill, 3);
    pulse_reset();
    step(1'b1, 1'b1);
    chk("mid_match", match, 0);
    chk("mid_fill1", fill, 1);
    chk("mid_window1", window, 4'b0001);
    step(1'b0, 1'b0);

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
